// File: rtl/csi_rx_link_ctrl.sv
// CSI-2 RX link sequencer: follows the D-PHY LP/HS burst cycle and gates the receive datapath.
// Defining CSI_RX_LINK_STATS_EN adds the err_count / burst_count statistics counters.
module csi_rx_link_ctrl #(
    parameter int unsigned LANES         = 2,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LP_MIN        = 4,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned SYNC_TIMEOUT  = 64,
    parameter int unsigned SKEW_MAX      = 2
) (
    input  logic             clock,
    input  logic             areset_n,
    input  logic             lp_detect,
    input  logic [LANES-1:0] aligned_valid,
    input  logic             err_clear,
    output logic             dp_reset,
    output logic             dp_enable,
    output logic             link_up,
    output logic [2:0]       state,
    output logic [7:0]       err_count,
    output logic [15:0]      burst_count
);

    typedef enum logic [2:0] {
        StResetHold = 3'd0,
        StLpWait    = 3'd1,
        StArmed     = 3'd2,
        StSettle    = 3'd3,
        StSync      = 3'd4,
        StRun       = 3'd5,
        StError     = 3'd6
    } state_e;

    localparam logic [15:0] RstLast    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] LpLast     = 16'(LP_MIN - 1);
    localparam logic [15:0] SettleLast = (SETTLE_CYCLES == 0) ? 16'd0 : 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SyncLast   = 16'(SYNC_TIMEOUT - 1);
    localparam logic [15:0] SkewLast   = 16'(SKEW_MAX - 1);

    logic        lp_meta;
    logic        lp_s;
    state_e      st_q;
    state_e      st_d;
    logic [15:0] cnt;
    logic        cnt_clr;
    logic        sync_err;
    logic        burst_done;
    logic        all_valid;
    logic        partial;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            lp_meta <= 1'b0;
            lp_s    <= 1'b0;
        end else begin
            lp_meta <= lp_detect;
            lp_s    <= lp_meta;
        end
    end

    assign all_valid = &aligned_valid;
    assign partial   = (|aligned_valid) && !all_valid;

    always_comb begin
        st_d       = st_q;
        cnt_clr    = 1'b0;
        sync_err   = 1'b0;
        burst_done = 1'b0;
        case (st_q)
            StResetHold: if (cnt == RstLast) st_d = StLpWait;
            StLpWait: begin
                if (!lp_s) cnt_clr = 1'b1;
                else if (cnt == LpLast) st_d = StArmed;
            end
            StArmed: if (!lp_s) st_d = (SETTLE_CYCLES == 0) ? StSync : StSettle;
            StSettle: begin
                if (lp_s) st_d = StArmed;
                else if (cnt == SettleLast) st_d = StSync;
            end
            StSync: begin
                if (lp_s) begin
                    st_d     = StArmed;
                    sync_err = 1'b1;
                end else if (all_valid) begin
                    st_d = StRun;
                end else if (cnt == SyncLast) begin
                    st_d = StError;
                end
            end
            StRun: begin
                if (lp_s) begin
                    st_d       = StArmed;
                    burst_done = 1'b1;
                end else if (!partial) begin
                    cnt_clr = 1'b1;
                end else if (cnt == SkewLast) begin
                    st_d = StError;
                end
            end
            StError: st_d = StResetHold;
            default: st_d = StResetHold;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            st_q      <= StResetHold;
            cnt       <= '0;
            dp_reset  <= 1'b1;
            dp_enable <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            st_q <= st_d;
            if ((st_d != st_q) || cnt_clr) cnt <= '0;
            else if (cnt != 16'hFFFF)      cnt <= cnt + 16'd1;
            dp_reset  <= (st_d == StResetHold);
            dp_enable <= (st_d == StSync) || (st_d == StRun);
            link_up   <= (st_d == StRun);
        end
    end

    assign state = st_q;

`ifdef CSI_RX_LINK_STATS_EN
    logic err_inc;
    assign err_inc = sync_err || (st_d == StError);

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            err_count   <= '0;
            burst_count <= '0;
        end else if (err_clear) begin
            err_count   <= '0;
            burst_count <= '0;
        end else begin
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (burst_done) burst_count <= burst_count + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = err_clear ^ sync_err ^ burst_done;
    assign err_count    = '0;
    assign burst_count  = '0;
`endif

endmodule
